// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: architectural register file, source-index decode, write-back
// bypass, and a one-deep valid/ready pipeline register feeding execute.
module operand_fetch_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 16,
   parameter int unsigned AW      = 4,
   parameter int unsigned RA_IDX  = 15,
   parameter int unsigned RD_LSB  = 22,
   parameter int unsigned RS1_LSB = 18,
   parameter int unsigned RS2_LSB = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic            in_is_ret,
   input  logic            in_is_st,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [31:0]     out_inst
);

   localparam logic [AW-1:0] RA = AW'(RA_IDX);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            accept;
   logic            drain;

   always_comb begin
      rs1 = in_is_ret ? RA : in_inst[RS1_LSB +: AW];
      rs2 = in_is_st  ? in_inst[RD_LSB +: AW] : in_inst[RS2_LSB +: AW];
   end

   // Same-cycle write-back wins over the array so the consumer never sees stale data.
   always_comb begin
      rd1 = (wb_en && (wb_addr == rs1)) ? wb_data : regs[rs1];
      rd2 = (wb_en && (wb_addr == rs2)) ? wb_data : regs[rs2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en) begin
         regs[wb_addr] <= wb_data;
      end
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_inst  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_op1   <= rd1;
         out_op2   <= rd2;
         out_inst  <= in_inst;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule
